// File: rtl/drive_cmd_pkg.sv
// Shared types and constants for the drive command shaping stage.
package drive_cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RAMP     = 2'd1,
    ST_FAILSAFE = 2'd2
  } state_e;

  localparam int unsigned DIR_MSB = 15;
  localparam int unsigned DIR_LSB = 8;
  localparam int unsigned SPD_MSB = 7;
  localparam int unsigned SPD_LSB = 0;

  localparam logic [7:0] DIR_CENTER_DEF  = 8'h80;
  localparam logic [7:0] SPD_NEUTRAL_DEF = 8'h80;

endpackage

// File: rtl/drive_step_tick.sv
// Free-running prescaler producing a one-cycle ramp step pulse every STEP_DIV cycles.
module drive_step_tick #(
  parameter int unsigned STEP_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int unsigned CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

  logic [CW-1:0] cnt_q;

  assign tick_o = (cnt_q == LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (tick_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/drive_cmd_shaper.sv
// Command shaper ahead of the PWM block: direction register, slew-limited speed, watchdog.
// Optional build macro CMD_DIR_CLAMP_EN saturates accepted direction to [DIR_MIN, DIR_MAX].
module drive_cmd_shaper
  import drive_cmd_pkg::*;
#(
  parameter int unsigned STEP_DIV    = 4,
  parameter logic [7:0]  STEP        = 8'd8,
  parameter int unsigned TIMEOUT_CYC = 1000,
  parameter logic [7:0]  DIR_CENTER  = DIR_CENTER_DEF,
  parameter logic [7:0]  SPD_NEUTRAL = SPD_NEUTRAL_DEF,
  parameter logic [7:0]  DIR_MIN     = 8'h20,
  parameter logic [7:0]  DIR_MAX     = 8'hE0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_data,
  output logic [15:0] data_out,
  output logic        failsafe,
  output logic        ramping
);

  localparam int unsigned WDW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYC - 1);

  if (STEP_DIV < 1) begin : g_bad_step_div
    $error("drive_cmd_shaper: STEP_DIV must be at least 1");
  end
  if (STEP == 8'd0) begin : g_bad_step
    $error("drive_cmd_shaper: STEP must be at least 1");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("drive_cmd_shaper: TIMEOUT_CYC must be at least 2");
  end
  if (DIR_MIN > DIR_MAX) begin : g_bad_clamp
    $error("drive_cmd_shaper: DIR_MIN must not exceed DIR_MAX");
  end

  state_e          state_q, state_d;
  logic [7:0]      dir_q, dir_d;
  logic [7:0]      cur_q, cur_d;
  logic [7:0]      tgt_q, tgt_d;
  logic [WDW-1:0]  wd_q, wd_d;
  logic            failsafe_q;
  logic            ramping_q;

  logic            tick;
  logic            accept;
  logic            timeout;
  logic [7:0]      dir_in;
  logic [7:0]      ramp_cur;
  logic signed [8:0] diff;
  logic signed [8:0] mag;

  drive_step_tick #(
    .STEP_DIV (STEP_DIV)
  ) u_step_tick (
    .clk_i  (clk),
    .rst_i  (rst),
    .tick_o (tick)
  );

  assign cmd_ready = ~rst;
  assign accept    = cmd_valid & cmd_ready;
  assign timeout   = (wd_q == WD_LAST) && (state_q != ST_FAILSAFE);

  always_comb begin
    dir_in = cmd_data[DIR_MSB:DIR_LSB];
`ifdef CMD_DIR_CLAMP_EN
    if (dir_in < DIR_MIN) begin
      dir_in = DIR_MIN;
    end else if (dir_in > DIR_MAX) begin
      dir_in = DIR_MAX;
    end
`endif
  end

  // Ramp always works from the registered target, so a same-cycle retarget takes effect next tick.
  always_comb begin
    diff     = $signed({1'b0, tgt_q}) - $signed({1'b0, cur_q});
    mag      = diff[8] ? -diff : diff;
    ramp_cur = cur_q;
    if (tick) begin
      if ($unsigned(mag) <= {1'b0, STEP}) begin
        ramp_cur = tgt_q;
      end else if (diff[8]) begin
        ramp_cur = cur_q - STEP;
      end else begin
        ramp_cur = cur_q + STEP;
      end
    end
  end

  always_comb begin
    dir_d   = dir_q;
    tgt_d   = tgt_q;
    cur_d   = ramp_cur;
    wd_d    = wd_q;
    state_d = state_q;
    if (accept) begin
      dir_d   = dir_in;
      tgt_d   = cmd_data[SPD_MSB:SPD_LSB];
      wd_d    = '0;
      state_d = (tgt_d != cur_d) ? ST_RAMP : ST_IDLE;
    end else if (timeout) begin
      dir_d   = DIR_CENTER;
      tgt_d   = SPD_NEUTRAL;
      state_d = ST_FAILSAFE;
    end else begin
      if (wd_q != WD_LAST) begin
        wd_d = wd_q + 1'b1;
      end
      if (state_q == ST_RAMP && cur_d == tgt_d) begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      dir_q      <= DIR_CENTER;
      cur_q      <= SPD_NEUTRAL;
      tgt_q      <= SPD_NEUTRAL;
      wd_q       <= '0;
      failsafe_q <= 1'b0;
      ramping_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      cur_q      <= cur_d;
      tgt_q      <= tgt_d;
      wd_q       <= wd_d;
      failsafe_q <= (state_d == ST_FAILSAFE);
      ramping_q  <= (cur_d != tgt_d);
    end
  end

  assign data_out[DIR_MSB:DIR_LSB] = dir_q;
  assign data_out[SPD_MSB:SPD_LSB] = cur_q;
  assign failsafe = failsafe_q;
  assign ramping  = ramping_q;

endmodule
